key_collect: RTL and testbench
==============================

KEY_COLLECT -- requirements
Module: key_collect

Interface
REQ-001 Parameter HOLD_FRAMES, default 30: frame_tick pulses pick must stay held over a key to collect it.
REQ-002 Parameter PLAYER_W, default 16: player box width, 320x240 pixels.
REQ-003 Parameter PLAYER_H, default 16: player box height, 320x240 pixels.
REQ-004 clk  input  1  system clock; the block SHALL use this single clock domain.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 state  input  4  game state: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
REQ-007 player_x  input  9  player box left edge, 0..319.
REQ-008 player_y  input  9  player box top edge, 0..239.
REQ-009 pick  input  1  action button level, already debounced.
REQ-010 frame_tick  input  1  one-clk pulse per video frame.
REQ-011 key_find  output  2  keys collected: 0=key1 shown, 1=key2 shown, 2=key3 shown, 3=all keys, door phase; drives the renderer.
REQ-012 hold_cnt  output  5  frames held on the current key, for a progress bar.
REQ-013 key_taken  output  1  one-clk pulse when a key is collected.
REQ-014 stage_clear  output  1  one-clk pulse when the door is opened.

Function
REQ-015 Key boxes, inclusive-exclusive, 320x240 coords: key1 x[65,85) y[35,55); key2 x[235,255) y[35,55); key3 x[235,255) y[205,225); door x[145,175) y[0,16).
REQ-016 Target is the key box indexed by key_find (0..2), or the door when key_find==3.
REQ-017 overlap SHALL be true when player_x<bx1, player_x+PLAYER_W>bx0, player_y<by1, player_y+PLAYER_H>by0; sums SHALL use 10 bits so nothing wraps.
REQ-018 FSM states: IDLE, HOLD, WAIT_REL, CLEARED; all outputs registered.
REQ-019 IDLE -> HOLD when state==STAGE1, key_find<3, pick, and overlap; hold_cnt=0 on entry.
REQ-020 IDLE with key_find==3, state==STAGE1, pick, and door overlap -> CLEARED; stage_clear=1 for exactly that one cycle.
REQ-021 HOLD abort: if pick==0, !overlap, or state!=STAGE1 -> IDLE with hold_cnt=0; abort SHALL take priority over a frame_tick in the same cycle.
REQ-022 HOLD, no abort, frame_tick, hold_cnt<HOLD_FRAMES-1 -> hold_cnt+1.
REQ-023 HOLD, no abort, frame_tick, hold_cnt==HOLD_FRAMES-1 -> key_find+1, key_taken=1 one cycle, hold_cnt=0, go to WAIT_REL; latency from the HOLD_FRAMES-th tick to key_taken is 1 clk.
REQ-024 WAIT_REL -> IDLE when pick==0, so a held button cannot chain to the next key or the door.
REQ-025 CLEARED is held while state is STAGE1 or SUCCESS1; key_find stays 3 and no further pulses occur.
REQ-026 key_find SHALL saturate at 3 and never wrap to 0 except by clear.
REQ-027 Clear: when state is not STAGE1 and not SUCCESS1, next clk -> key_find=0, hold_cnt=0, FSM=IDLE, pulses 0; this covers TITLE, FAIL, and other stages.
REQ-028 While state==SUCCESS1, FSM, key_find, and hold_cnt SHALL freeze.

Reset
REQ-029 rst_n==0 SHALL immediately force FSM=IDLE, key_find=0, hold_cnt=0, key_taken=0, stage_clear=0, independent of clk.
REQ-030 Reset mid-HOLD SHALL discard partial progress; no key_taken on release.
REQ-031 After rst_n rises, first transition SHALL be no earlier than the next clk edge.

Verification
REQ-032 state=2, player (70,40), pick=1, 30 frame_ticks -> key_taken 1 clk after 30th tick, key_find 0->1, hold_cnt 29->0.
REQ-033 Same as REQ-032 but pick drops after 10 ticks -> hold_cnt 0, key_find stays 0, no key_taken; pick=0 and frame_tick in the same cycle -> abort wins.
REQ-034 After key1, keep pick=1 at (240,40) -> stays WAIT_REL, hold_cnt 0; release, then press -> key2 hold starts.
REQ-035 Collect all 3 keys (key3 at (240,210)), move to (150,5), pick -> stage_clear one pulse, key_find=3; further picks give no pulse.
REQ-036 key_find=2 mid-HOLD, state->8 (FAIL) -> next clk key_find=0, hold_cnt=0; rst_n low mid-HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/key_collect.sv
// rtl/key_collect.sv - collect three keys by holding pick over each, then open the door
//
// Ports:
//   clk, rst_n       single clock domain, asynchronous active-low reset
//   state [3:0]      game state (STAGE1=2, SUCCESS1=3 keep progress; anything else clears)
//   player_x [8:0]   player box left edge, 0..319
//   player_y [8:0]   player box top edge, 0..239
//   pick             debounced action button level
//   frame_tick       one-clk pulse per video frame
//   key_find [1:0]   keys collected so far (3 = door phase)
//   hold_cnt [4:0]   frames held on the current key
//   key_taken        one-clk pulse when a key is collected
//   stage_clear      one-clk pulse when the door opens
module key_collect #(
  parameter int HOLD_FRAMES = 30,
  parameter int PLAYER_W    = 16,
  parameter int PLAYER_H    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic       pick,
  input  logic       frame_tick,
  output logic [1:0] key_find,
  output logic [4:0] hold_cnt,
  output logic       key_taken,
  output logic       stage_clear
);

  localparam logic [3:0] ST_STAGE1   = 4'd2;
  localparam logic [3:0] ST_SUCCESS1 = 4'd3;
  localparam logic [4:0] HOLD_LAST   = 5'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL, CLEARED} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [1:0] key_find_d;
  logic [4:0] hold_cnt_d;
  logic       key_taken_d, stage_clear_d;

  logic [9:0] bx0, bx1, by0, by1;
  logic [9:0] px, py;
  logic       overlap;

  // Target box follows collection progress; index 3 is the door.
  always_comb begin
    bx0 = 10'd65;  bx1 = 10'd85;  by0 = 10'd35;  by1 = 10'd55;
    case (key_find)
      2'd0: begin bx0 = 10'd65;  bx1 = 10'd85;  by0 = 10'd35;  by1 = 10'd55;  end
      2'd1: begin bx0 = 10'd235; bx1 = 10'd255; by0 = 10'd35;  by1 = 10'd55;  end
      2'd2: begin bx0 = 10'd235; bx1 = 10'd255; by0 = 10'd205; by1 = 10'd225; end
      default: begin bx0 = 10'd145; bx1 = 10'd175; by0 = 10'd0; by1 = 10'd16; end
    endcase
  end

  // 10-bit sums so the right/bottom edge never wraps near the screen limit.
  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};
  assign overlap = (px < bx1) && ((px + 10'(PLAYER_W)) > bx0) &&
                   (py < by1) && ((py + 10'(PLAYER_H)) > by0);

  always_comb begin
    fsm_d         = fsm_q;
    key_find_d    = key_find;
    hold_cnt_d    = hold_cnt;
    key_taken_d   = 1'b0;
    stage_clear_d = 1'b0;
    if (state != ST_STAGE1 && state != ST_SUCCESS1) begin
      fsm_d      = IDLE;
      key_find_d = 2'd0;
      hold_cnt_d = 5'd0;
    end else if (state == ST_STAGE1) begin
      // SUCCESS1 falls through with everything frozen.
      case (fsm_q)
        IDLE: begin
          if (pick && overlap) begin
            if (key_find != 2'd3) begin
              fsm_d      = HOLD;
              hold_cnt_d = 5'd0;
            end else begin
              fsm_d         = CLEARED;
              stage_clear_d = 1'b1;
            end
          end
        end
        HOLD: begin
          // Abort is checked before frame_tick so a release on a tick never counts.
          if (!pick || !overlap) begin
            fsm_d      = IDLE;
            hold_cnt_d = 5'd0;
          end else if (frame_tick) begin
            if (hold_cnt >= HOLD_LAST) begin
              if (key_find != 2'd3) key_find_d = key_find + 2'd1;
              key_taken_d = 1'b1;
              hold_cnt_d  = 5'd0;
              fsm_d       = WAIT_REL;
            end else begin
              hold_cnt_d = hold_cnt + 5'd1;
            end
          end
        end
        WAIT_REL: begin
          if (!pick) fsm_d = IDLE;
        end
        CLEARED: begin
          fsm_d = CLEARED;
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      key_find    <= 2'd0;
      hold_cnt    <= 5'd0;
      key_taken   <= 1'b0;
      stage_clear <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      key_find    <= key_find_d;
      hold_cnt    <= hold_cnt_d;
      key_taken   <= key_taken_d;
      stage_clear <= stage_clear_d;
    end
  end

endmodule

// File: tb/tb_key_collect.sv
// tb/tb_key_collect.sv - self-checking bench for key_collect against a behavioural model
module tb_key_collect;

  localparam int HOLD = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd0;
  logic [8:0] player_x = 9'd0;
  logic [8:0] player_y = 9'd0;
  logic       pick = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] key_find;
  logic [4:0] hold_cnt;
  logic       key_taken;
  logic       stage_clear;

  key_collect #(.HOLD_FRAMES(HOLD), .PLAYER_W(16), .PLAYER_H(16)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .player_x(player_x), .player_y(player_y),
    .pick(pick), .frame_tick(frame_tick), .key_find(key_find), .hold_cnt(hold_cnt),
    .key_taken(key_taken), .stage_clear(stage_clear)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;

  // Model of the game rules: progress, frames held, and the "must let go" latch.
  int m_keys, m_held, m_taken, m_clr;
  bit m_holding, m_release, m_door;

  function automatic bit on_target(int k, int x, int y);
    int x0, x1, y0, y1;
    case (k)
      0: begin x0 = 65;  x1 = 85;  y0 = 35;  y1 = 55;  end
      1: begin x0 = 235; x1 = 255; y0 = 35;  y1 = 55;  end
      2: begin x0 = 235; x1 = 255; y0 = 205; y1 = 225; end
      default: begin x0 = 145; x1 = 175; y0 = 0; y1 = 16; end
    endcase
    return (x < x1) && (x + 16 > x0) && (y < y1) && (y + 16 > y0);
  endfunction

  task automatic model_reset();
    m_keys = 0; m_held = 0; m_taken = 0; m_clr = 0;
    m_holding = 0; m_release = 0; m_door = 0;
  endtask

  task automatic model_clock(int st, int x, int y, bit pk, bit tk);
    bit ov;
    ov = on_target(m_keys, x, y);
    m_taken = 0;
    m_clr = 0;
    if (st != 2 && st != 3) begin
      model_reset();
    end else if (st == 2) begin
      if (m_door) begin
        // door already open: nothing more happens
      end else if (m_release) begin
        if (!pk) m_release = 0;
      end else if (m_holding) begin
        if (!pk || !ov) begin
          m_holding = 0;
          m_held = 0;
        end else if (tk) begin
          if (m_held + 1 == HOLD) begin
            m_keys = (m_keys < 3) ? m_keys + 1 : 3;
            m_held = 0;
            m_holding = 0;
            m_release = 1;
            m_taken = 1;
          end else begin
            m_held++;
          end
        end
      end else if (pk && ov) begin
        if (m_keys < 3) begin
          m_holding = 1;
          m_held = 0;
        end else begin
          m_door = 1;
          m_clr = 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".key_find"}, 32'(key_find), 32'(m_keys));
    chk({tag, ".hold_cnt"}, 32'(hold_cnt), 32'(m_held));
    chk({tag, ".key_taken"}, 32'(key_taken), 32'(m_taken));
    chk({tag, ".stage_clear"}, 32'(stage_clear), 32'(m_clr));
  endtask

  task automatic step(int st, int x, int y, bit pk, bit tk);
    @(negedge clk);
    state = 4'(st);
    player_x = 9'(x);
    player_y = 9'(y);
    pick = pk;
    frame_tick = tk;
    model_clock(st, x, y, pk, tk);
    @(posedge clk);
    #1;
    chk_all("step");
  endtask

  // Press, hold for the full frame count, then let go.
  task automatic take_key(int x, int y);
    step(2, x, y, 1, 0);
    for (int i = 0; i < HOLD; i++) step(2, x, y, 1, 1);
    chk("key_taken_pulse", 32'(key_taken), 32'd1);
    step(2, x, y, 1, 0);
    chk("key_taken_one_cycle", 32'(key_taken), 32'd0);
    step(2, x, y, 0, 0);
  endtask

  initial begin
    int px, py, sel, st, r;
    bit pk;
    model_reset();
    #1;
    chk_all("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // Key1 collection with exact latency on the 30th tick.
    step(2, 70, 40, 1, 0);
    for (int i = 0; i < HOLD - 1; i++) step(2, 70, 40, 1, 1);
    chk("hold_cnt_29", 32'(hold_cnt), 32'd29);
    chk("no_key_before_30th", 32'(key_taken), 32'd0);
    step(2, 70, 40, 1, 1);
    chk("key1_taken", 32'(key_taken), 32'd1);
    chk("key_find_1", 32'(key_find), 32'd1);
    chk("hold_cnt_wrap", 32'(hold_cnt), 32'd0);

    // Held button moved onto key2 must not start a new hold.
    for (int i = 0; i < 5; i++) step(2, 240, 40, 1, 1);
    chk("wait_rel_hold0", 32'(hold_cnt), 32'd0);
    step(2, 240, 40, 0, 0);
    step(2, 240, 40, 1, 0);
    step(2, 240, 40, 1, 1);
    chk("key2_hold_starts", 32'(hold_cnt), 32'd1);

    // Partial hold then release on a tick cycle: abort wins.
    for (int i = 0; i < 9; i++) step(2, 240, 40, 1, 1);
    chk("partial_hold", 32'(hold_cnt), 32'd10);
    step(2, 240, 40, 0, 1);
    chk("abort_wins", 32'(hold_cnt), 32'd0);
    chk("abort_keys", 32'(key_find), 32'd1);

    take_key(240, 40);
    // Mid-hold on key3, then FAIL state clears everything next clock.
    step(2, 240, 210, 1, 0);
    for (int i = 0; i < 7; i++) step(2, 240, 210, 1, 1);
    step(8, 240, 210, 1, 1);
    chk("fail_clears_keys", 32'(key_find), 32'd0);
    chk("fail_clears_hold", 32'(hold_cnt), 32'd0);

    // All three keys, then door.
    take_key(70, 40);
    take_key(240, 40);
    take_key(240, 210);
    chk("three_keys", 32'(key_find), 32'd3);
    step(2, 150, 5, 1, 0);
    chk("stage_clear", 32'(stage_clear), 32'd1);
    step(2, 150, 5, 1, 0);
    step(2, 150, 5, 0, 0);
    step(2, 150, 5, 1, 0);
    chk("no_second_clear", 32'(stage_clear), 32'd0);
    step(3, 150, 5, 1, 1);
    chk("success_freeze", 32'(key_find), 32'd3);
    step(0, 150, 5, 0, 0);

    // Asynchronous reset in the middle of a hold.
    step(2, 70, 40, 1, 0);
    for (int i = 0; i < 12; i++) step(2, 70, 40, 1, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("reset_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step(2, 70, 40, 0, 0);

    // Randomized play: dwell on a target (or a random spot) for a stretch.
    for (int seg = 0; seg < 80; seg++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: begin px = 70;  py = 40;  end
        1: begin px = 240; py = 40;  end
        2: begin px = 240; py = 210; end
        3: begin px = 150; py = 5;   end
        default: begin px = $urandom_range(0, 319); py = $urandom_range(0, 239); end
      endcase
      for (int c = 0; c < 40; c++) begin
        r = $urandom_range(0, 39);
        st = (r == 0) ? 3 : (r == 1) ? $urandom_range(0, 8) : 2;
        pk = ($urandom_range(0, 15) != 0);
        step(st, px, py, pk, bit'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
